// File: rtl/miner_work_ctrl.sv
// miner_work_ctrl: paces nonces into the odo_keccak pipeline, tags returned verdicts and queues hits.
// Define MINER_WORK_CTRL_STATS_EN to add the saturating hash_count/hit_count outputs.
module miner_work_ctrl #(
    parameter int THROUGHPUT   = 8,
    parameter int MAX_INFLIGHT = 64,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [607:0] job_header,
    input  logic [255:0] job_target,
    input  logic [31:0]  job_nonce_first,
    input  logic [31:0]  job_nonce_last,
    output logic [607:0] hdr,
    output logic [255:0] tgt,
    output logic         issue,
    output logic [31:0]  issue_nonce,
    input  logic         res_valid,
    input  logic         res_hit,
    output logic         found_valid,
    output logic [31:0]  found_nonce,
    input  logic         found_ready,
    output logic         busy,
    output logic         done,
    output logic         overflow
`ifdef MINER_WORK_CTRL_STATS_EN
    ,
    output logic [47:0]  hash_count,
    output logic [31:0]  hit_count
`endif
);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam int PW = $clog2(THROUGHPUT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;
    state_t state_q, state_d;
    logic [PW-1:0] pace_q, pace_d;
    logic [IW-1:0] inflight_q, inflight_d;
    logic [31:0] next_q, next_d, last_q, last_d, ret_q, ret_d;
    logic [31:0] p_first_q, p_first_d, p_last_q, p_last_d;
    logic [607:0] hdr_q, hdr_d, p_hdr_q, p_hdr_d;
    logic [255:0] tgt_q, tgt_d, p_tgt_q, p_tgt_d;
    logic ovf_q, ovf_d;
    logic [31:0] mem_q [FIFO_DEPTH];
    logic [31:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic accept, load, counted, push, drop, pop, pace_end, from_pend;
    always_comb begin
        state_d    = state_q;
        pace_d     = pace_q;
        next_d     = next_q;
        last_d     = last_q;
        hdr_d      = hdr_q;
        tgt_d      = tgt_q;
        p_hdr_d    = p_hdr_q;
        p_tgt_d    = p_tgt_q;
        p_first_d  = p_first_q;
        p_last_d   = p_last_q;
        mem_d      = mem_q;
        load       = 1'b0;
        from_pend  = state_q == FLUSH;
        pace_end   = pace_q == PW'(THROUGHPUT - 1);
        job_ready  = state_q != FLUSH;
        accept     = job_valid && job_ready;
        issue      = state_q == RUN && pace_end && inflight_q < IW'(MAX_INFLIGHT);
        done       = state_q == DRAIN && inflight_q == '0;
        counted    = res_valid && state_q != FLUSH;
        pop        = found_ready && found_valid;
        push       = counted && res_hit && (cnt_q != CW'(FIFO_DEPTH) || pop);
        drop       = counted && res_hit && !push;
        inflight_d = inflight_q + IW'(issue) - IW'(res_valid);
        ret_d      = counted ? ret_q + 32'd1 : ret_q;
        ovf_d      = ovf_q || drop;
        if (push) mem_d[wr_q] = ret_q;
        wr_d       = wr_q + AW'(push);
        rd_d       = rd_q + AW'(pop);
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        case (state_q)
            IDLE:  load = accept;
            RUN: begin
                pace_d  = pace_end ? (issue ? '0 : pace_q) : pace_q + PW'(1);
                next_d  = issue ? next_q + 32'd1 : next_q;
                state_d = accept ? FLUSH : (issue && next_q == last_q) ? DRAIN : RUN;
            end
            DRAIN: begin
                state_d = done ? IDLE : accept ? FLUSH : DRAIN;
                load    = done && accept;
            end
            FLUSH: load = inflight_q == '0;
            default: ;
        endcase
        // An aborting job waits here until every old verdict has come back.
        if (accept && !load) begin
            p_hdr_d   = job_header;
            p_tgt_d   = job_target;
            p_first_d = job_nonce_first;
            p_last_d  = job_nonce_last;
        end
        if (load) begin
            state_d = RUN;
            pace_d  = '0;
            hdr_d   = from_pend ? p_hdr_q : job_header;
            tgt_d   = from_pend ? p_tgt_q : job_target;
            next_d  = from_pend ? p_first_q : job_nonce_first;
            last_d  = from_pend ? p_last_q : job_nonce_last;
            ret_d   = next_d;
        end
        if (accept || load) ovf_d = 1'b0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pace_q     <= '0;
            inflight_q <= '0;
            next_q     <= '0;
            last_q     <= '0;
            ret_q      <= '0;
            p_first_q  <= '0;
            p_last_q   <= '0;
            hdr_q      <= '0;
            tgt_q      <= '0;
            p_hdr_q    <= '0;
            p_tgt_q    <= '0;
            ovf_q      <= 1'b0;
            mem_q      <= '{default: '0};
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pace_q     <= pace_d;
            inflight_q <= inflight_d;
            next_q     <= next_d;
            last_q     <= last_d;
            ret_q      <= ret_d;
            p_first_q  <= p_first_d;
            p_last_q   <= p_last_d;
            hdr_q      <= hdr_d;
            tgt_q      <= tgt_d;
            p_hdr_q    <= p_hdr_d;
            p_tgt_q    <= p_tgt_d;
            ovf_q      <= ovf_d;
            mem_q      <= mem_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
        end
    end
    assign hdr         = hdr_q;
    assign tgt         = tgt_q;
    assign issue_nonce = next_q;
    assign found_valid = cnt_q != '0;
    assign found_nonce = mem_q[rd_q];
    assign busy        = state_q != IDLE;
    assign overflow    = ovf_q;
`ifdef MINER_WORK_CTRL_STATS_EN
    logic [47:0] hash_count_q, hash_count_d;
    logic [31:0] hit_count_q, hit_count_d;
    always_comb begin
        hash_count_d = (counted && !(&hash_count_q)) ? hash_count_q + 48'd1 : hash_count_q;
        hit_count_d  = ((push || drop) && !(&hit_count_q)) ? hit_count_q + 32'd1 : hit_count_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hash_count_q <= '0;
            hit_count_q  <= '0;
        end else begin
            hash_count_q <= hash_count_d;
            hit_count_q  <= hit_count_d;
        end
    end
    assign hash_count = hash_count_q;
    assign hit_count  = hit_count_q;
`endif
endmodule
